multi_hash_table: RTL and testbench

MULTI_HASH_TABLE -- requirements
Module: multi_hash_table

---
 rtl/multi_hash_table.sv | 228 ++++++++++++++++++++++
 tb/tb_multi_hash_table.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_hash_table.sv
// multi_hash_table: multi-way H3-hashed key/value table with read, write and delete.
// Ports: clk/reset, request (key_in, data_in, delete_write_read_i, valid_i, ready_o),
// response (valid_o, ready_i, read_data_o, hit_table_o, result flags),
// flush_i, occupancy_o.
module multi_hash_table #(
    parameter int KEY_WIDTH        = 4,
    parameter int DATA_WIDTH       = 8,
    parameter int NUMBER_OF_TABLES = 2,
    parameter int ADR_WIDTH        = 1,
    parameter logic [NUMBER_OF_TABLES*KEY_WIDTH*ADR_WIDTH-1:0] MATRIX = 8'h21,
    parameter bit OVERWRITE        = 1'b0,
    localparam int HW    = (NUMBER_OF_TABLES > 1) ? $clog2(NUMBER_OF_TABLES) : 1,
    localparam int DEPTH = 1 << ADR_WIDTH,
    localparam int SLOTS = NUMBER_OF_TABLES * DEPTH,
    localparam int OW    = $clog2(SLOTS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [KEY_WIDTH-1:0]  key_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [1:0]            delete_write_read_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] read_data_o,
    output logic [HW-1:0]         hit_table_o,
    output logic                  no_deletion_target_o,
    output logic                  no_write_space_o,
    output logic                  no_element_found_o,
    output logic                  key_already_present_o,
    input  logic                  flush_i,
    output logic [OW-1:0]         occupancy_o
);

    localparam logic [1:0] OP_READ   = 2'b01;
    localparam logic [1:0] OP_WRITE  = 2'b10;
    localparam logic [1:0] OP_DELETE = 2'b11;

    typedef enum logic [1:0] {IDLE, READ, DECIDE, RESP} state_t;

    state_t state, state_nxt;

    logic [NUMBER_OF_TABLES-1:0][DEPTH-1:0] valid_q;
    logic [KEY_WIDTH-1:0]  key_mem  [NUMBER_OF_TABLES][DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [NUMBER_OF_TABLES][DEPTH];

    logic [KEY_WIDTH-1:0]  key_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [1:0]            op_q;

    logic [ADR_WIDTH-1:0]        addr      [NUMBER_OF_TABLES];
    logic [NUMBER_OF_TABLES-1:0] slot_valid;
    logic [KEY_WIDTH-1:0]        slot_key  [NUMBER_OF_TABLES];
    logic [DATA_WIDTH-1:0]       slot_data [NUMBER_OF_TABLES];

    logic          hit, free;
    logic [HW-1:0] hit_idx, free_idx;
    logic          accept, in_decide;
    logic          do_insert, do_update, do_delete;
    logic [OW-1:0] occ_q;

    logic [DATA_WIDTH-1:0] rd_nxt, rd_q;
    logic [HW-1:0]         ht_nxt, ht_q;
    logic [3:0]            flg_nxt, flg_q;

    assign ready_o   = (state == IDLE) && !flush_i;
    assign accept    = valid_i && ready_o && (delete_write_read_i != 2'b00);
    assign in_decide = (state == DECIDE);

    // H3 hash of the latched key, one address per table
    always_comb begin
        for (int i = 0; i < NUMBER_OF_TABLES; i++) begin
            addr[i] = '0;
            for (int b = 0; b < ADR_WIDTH; b++) begin
                for (int k = 0; k < KEY_WIDTH; k++) begin
                    addr[i][b] = addr[i][b] ^ (key_q[k] &
                        MATRIX[(i*KEY_WIDTH+k)*ADR_WIDTH+b]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            op_q  <= 2'b00;
        end else begin
            state <= state_nxt;
            if (accept) op_q <= delete_write_read_i;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = READ;
            READ:    state_nxt = DECIDE;
            DECIDE:  state_nxt = RESP;
            RESP:    if (ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Payload storage and the per-operation snapshot need no reset:
    // valid_q and the FSM decide whether any of it is ever observed.
    always_ff @(posedge clk) begin
        if (accept) begin
            key_q  <= key_in;
            data_q <= data_in;
        end
        if (state == READ) begin
            for (int i = 0; i < NUMBER_OF_TABLES; i++) begin
                slot_valid[i] <= valid_q[i][addr[i]];
                slot_key[i]   <= key_mem[i][addr[i]];
                slot_data[i]  <= data_mem[i][addr[i]];
            end
        end
        if (do_insert) begin
            key_mem[free_idx][addr[free_idx]]  <= key_q;
            data_mem[free_idx][addr[free_idx]] <= data_q;
        end
        if (do_update) begin
            data_mem[hit_idx][addr[hit_idx]] <= data_q;
        end
    end

    // Scan downwards so the lowest matching/free table wins
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = NUMBER_OF_TABLES - 1; i >= 0; i--) begin
            if (slot_valid[i] && (slot_key[i] == key_q)) begin
                hit     = 1'b1;
                hit_idx = HW'(i);
            end
            if (!slot_valid[i]) begin
                free     = 1'b1;
                free_idx = HW'(i);
            end
        end
    end

    assign do_update = in_decide && (op_q == OP_WRITE) && hit && OVERWRITE;
    assign do_insert = in_decide && (op_q == OP_WRITE) && !hit && free;
    assign do_delete = in_decide && (op_q == OP_DELETE) && hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            occ_q   <= '0;
        end else if ((state == IDLE) && flush_i) begin
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            if (do_insert) begin
                valid_q[free_idx][addr[free_idx]] <= 1'b1;
                if (occ_q != OW'(SLOTS)) occ_q <= occ_q + 1'b1;
            end
            if (do_delete) begin
                valid_q[hit_idx][addr[hit_idx]] <= 1'b0;
                if (occ_q != '0) occ_q <= occ_q - 1'b1;
            end
        end
    end

    // Flag order: {no_deletion_target, no_write_space,
    //              no_element_found, key_already_present}
    always_comb begin
        rd_nxt  = '0;
        ht_nxt  = '0;
        flg_nxt = 4'b0000;
        unique case (1'b1)
            (op_q == OP_READ): begin
                if (hit) begin
                    rd_nxt = slot_data[hit_idx];
                    ht_nxt = hit_idx;
                end else begin
                    flg_nxt[1] = 1'b1;
                end
            end
            (op_q == OP_WRITE): begin
                if (hit) begin
                    flg_nxt[0] = 1'b1;
                    ht_nxt     = hit_idx;
                end else if (free) begin
                    ht_nxt = free_idx;
                end else begin
                    flg_nxt[2] = 1'b1;
                end
            end
            (op_q == OP_DELETE): begin
                if (hit) ht_nxt = hit_idx;
                else     flg_nxt[3] = 1'b1;
            end
            default: ;
        endcase
    end

    // Response is cleared on handshake so outputs read zero outside RESP
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q  <= '0;
            ht_q  <= '0;
            flg_q <= 4'b0000;
        end else if (in_decide) begin
            rd_q  <= rd_nxt;
            ht_q  <= ht_nxt;
            flg_q <= flg_nxt;
        end else if ((state == RESP) && ready_i) begin
            rd_q  <= '0;
            ht_q  <= '0;
            flg_q <= 4'b0000;
        end
    end

    assign valid_o               = (state == RESP);
    assign read_data_o           = rd_q;
    assign hit_table_o           = ht_q;
    assign no_deletion_target_o  = flg_q[3];
    assign no_write_space_o      = flg_q[2];
    assign no_element_found_o    = flg_q[1];
    assign key_already_present_o = flg_q[0];
    assign occupancy_o           = occ_q;

endmodule

// File: tb/tb_multi_hash_table.sv
// tb_multi_hash_table: directed bench for multi_hash_table, two instances
// (OVERWRITE 0 and 1) driven identically and checked against a table model.
module tb_multi_hash_table;

    localparam logic [1:0] NOP = 2'b00;
    localparam logic [1:0] RD  = 2'b01;
    localparam logic [1:0] WR  = 2'b10;
    localparam logic [1:0] DEL = 2'b11;
    localparam logic [7:0] MAT = 8'h21;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] key_in;
    logic [7:0] data_in;
    logic [1:0] op;
    logic       valid_i, ready_i, flush_i;

    logic       ready_o0, valid_o0, nd0, nws0, nef0, kap0;
    logic [7:0] rd0;
    logic [0:0] ht0;
    logic [2:0] occ0;
    logic       ready_o1, valid_o1, nd1, nws1, nef1, kap1;
    logic [7:0] rd1;
    logic [0:0] ht1;
    logic [2:0] occ1;

    multi_hash_table #(.OVERWRITE(1'b0)) u0 (
        .clk(clk), .reset(reset), .key_in(key_in), .data_in(data_in),
        .delete_write_read_i(op), .valid_i(valid_i), .ready_o(ready_o0),
        .valid_o(valid_o0), .ready_i(ready_i), .read_data_o(rd0),
        .hit_table_o(ht0), .no_deletion_target_o(nd0),
        .no_write_space_o(nws0), .no_element_found_o(nef0),
        .key_already_present_o(kap0), .flush_i(flush_i),
        .occupancy_o(occ0)
    );

    multi_hash_table #(.OVERWRITE(1'b1)) u1 (
        .clk(clk), .reset(reset), .key_in(key_in), .data_in(data_in),
        .delete_write_read_i(op), .valid_i(valid_i), .ready_o(ready_o1),
        .valid_o(valid_o1), .ready_i(ready_i), .read_data_o(rd1),
        .hit_table_o(ht1), .no_deletion_target_o(nd1),
        .no_write_space_o(nws1), .no_element_found_o(nef1),
        .key_already_present_o(kap1), .flush_i(flush_i),
        .occupancy_o(occ1)
    );

    int compared = 0;
    int failed   = 0;

    // model: [instance][table][address]
    bit         mval [2][2][2];
    logic [3:0] mkey [2][2][2];
    logic [7:0] mdat [2][2][2];
    int         mocc [2];

    bit         epend [2];
    logic [7:0] erd   [2];
    int         eht   [2];
    logic [3:0] eflg  [2];
    int         eocc  [2];

    int r_rd0, r_rd1, r_ht0, r_ht1, r_occ0, r_lat, r_held;
    int r_nd0, r_nws0, r_nef0, r_kap0, r_kap1;

    function automatic int haddr(int t, logic [3:0] k);
        int a = 0;
        for (int kk = 0; kk < 4; kk++)
            if (k[kk] && MAT[t*4+kk]) a ^= 1;
        return a;
    endfunction

    task automatic model_clear();
        for (int m = 0; m < 2; m++) begin
            for (int t = 0; t < 2; t++)
                for (int a = 0; a < 2; a++) mval[m][t][a] = 1'b0;
            mocc[m]  = 0;
            epend[m] = 1'b0;
        end
    endtask

    // flags: {no_deletion_target, no_write_space, no_element_found, key_present}
    task automatic model_accept(int m, logic [1:0] o, logic [3:0] k,
                                logic [7:0] d);
        int hit = -1;
        int fr  = -1;
        int a[2];
        for (int t = 0; t < 2; t++) begin
            a[t] = haddr(t, k);
            if (hit < 0 && mval[m][t][a[t]] && mkey[m][t][a[t]] == k) hit = t;
            if (fr < 0 && !mval[m][t][a[t]]) fr = t;
        end
        erd[m]  = 8'h00;
        eht[m]  = 0;
        eflg[m] = 4'b0000;
        case (o)
            RD: if (hit >= 0) begin
                    erd[m] = mdat[m][hit][a[hit]];
                    eht[m] = hit;
                end else eflg[m] = 4'b0010;
            WR: if (hit >= 0) begin
                    eflg[m] = 4'b0001;
                    eht[m]  = hit;
                    if (m == 1) mdat[m][hit][a[hit]] = d;
                end else if (fr >= 0) begin
                    mval[m][fr][a[fr]] = 1'b1;
                    mkey[m][fr][a[fr]] = k;
                    mdat[m][fr][a[fr]] = d;
                    eht[m] = fr;
                    if (mocc[m] < 4) mocc[m]++;
                end else eflg[m] = 4'b0100;
            DEL: if (hit >= 0) begin
                    mval[m][hit][a[hit]] = 1'b0;
                    eht[m] = hit;
                    if (mocc[m] > 0) mocc[m]--;
                end else eflg[m] = 4'b1000;
            default: ;
        endcase
        eocc[m]  = mocc[m];
        epend[m] = (o != NOP);
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_inst(int m, logic v, logic r, logic [7:0] rd,
                              logic [0:0] ht, logic nd, logic nws,
                              logic nef, logic kap, logic [2:0] occ);
        logic [3:0] f;
        f = {nd, nws, nef, kap};
        compared++;
        if (v) begin
            if (!epend[m] || r !== 1'b0 || rd !== erd[m] ||
                ht !== 1'(eht[m]) || f !== eflg[m] ||
                occ !== 3'(eocc[m])) begin
                failed++;
                $display("FAIL resp%0d @%0t: got rd=%h ht=%0d flg=%b occ=%0d rdy=%b pend=%b exp rd=%h ht=%0d flg=%b occ=%0d",
                         m, $time, rd, ht, f, occ, r, epend[m],
                         erd[m], eht[m], eflg[m], eocc[m]);
            end
            if (ready_i) epend[m] = 1'b0;
        end else begin
            if (f !== 4'b0000) begin
                failed++;
                $display("FAIL idle_flags%0d @%0t: got %b expected 0000",
                         m, $time, f);
            end
            if (r) begin
                compared++;
                if (occ !== 3'(mocc[m])) begin
                    failed++;
                    $display("FAIL idle_occ%0d @%0t: got %0d expected %0d",
                             m, $time, occ, mocc[m]);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            check_inst(0, valid_o0, ready_o0, rd0, ht0, nd0, nws0, nef0,
                       kap0, occ0);
            check_inst(1, valid_o1, ready_o1, rd1, ht1, nd1, nws1, nef1,
                       kap1, occ1);
        end
    end

    task automatic do_op(input logic [1:0] o, input logic [3:0] k,
                         input logic [7:0] d, input int hold);
        bit ok;
        @(posedge clk);
        #1;
        op      = o;
        key_in  = k;
        data_in = d;
        valid_i = 1'b1;
        ready_i = (hold == 0);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (ready_o0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            compared++;
            failed++;
            $display("FAIL accept_timeout: ready_o stayed 0, required 1");
            valid_i = 1'b0;
            ready_i = 1'b1;
            return;
        end
        @(posedge clk);
        model_accept(0, o, k, d);
        model_accept(1, o, k, d);
        #1 valid_i = 1'b0;
        if (o == NOP) return;
        ok    = 1'b0;
        r_lat = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            r_lat++;
            if (valid_o0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            compared++;
            failed++;
            $display("FAIL resp_timeout: valid_o stayed 0, required 1");
            epend[0] = 1'b0;
            epend[1] = 1'b0;
            ready_i  = 1'b1;
            return;
        end
        chk("latency", r_lat, 3);
        r_rd0  = rd0;
        r_rd1  = rd1;
        r_ht0  = ht0;
        r_ht1  = ht1;
        r_occ0 = occ0;
        r_nd0  = nd0;
        r_nws0 = nws0;
        r_nef0 = nef0;
        r_kap0 = kap0;
        r_kap1 = kap1;
        r_held = 0;
        for (int c = 0; c < hold; c++) begin
            @(posedge clk);
            #1;
            if (valid_o0 && !ready_o0 && rd0 == 8'(r_rd0)) r_held++;
        end
        ready_i = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        key_in  = 4'h0;
        data_in = 8'h00;
        op      = NOP;
        valid_i = 1'b0;
        ready_i = 1'b1;
        flush_i = 1'b0;
        model_clear();
        #1;
        chk("rst_valid", valid_o0, 0);
        chk("rst_occ", occ0, 0);
        chk("rst_rd", rd0, 0);
        chk("rst_flags", {nd0, nws0, nef0, kap0, ht0}, 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;

        do_op(WR, 4'h1, 8'hAA, 0);
        chk("w1_ht", r_ht0, 0);
        do_op(WR, 4'h3, 8'hBB, 0);
        chk("w3_ht", r_ht0, 1);
        do_op(WR, 4'h5, 8'hCC, 0);
        chk("w5_ht", r_ht0, 1);
        chk("w5_occ", r_occ0, 3);
        do_op(WR, 4'h7, 8'h77, 0);
        chk("w7_nws", r_nws0, 1);
        chk("w7_occ", r_occ0, 3);
        do_op(RD, 4'h3, 8'h00, 0);
        chk("r3_data", r_rd0, 8'hBB);
        chk("r3_ht", r_ht0, 1);
        do_op(WR, 4'h1, 8'hDD, 0);
        chk("w1dup_kap0", r_kap0, 1);
        chk("w1dup_kap1", r_kap1, 1);
        do_op(RD, 4'h1, 8'h00, 0);
        chk("r1_noovw", r_rd0, 8'hAA);
        chk("r1_ovw", r_rd1, 8'hDD);
        do_op(DEL, 4'h1, 8'h00, 0);
        chk("d1_occ", r_occ0, 2);
        chk("d1_ht", r_ht0, 0);
        do_op(DEL, 4'h1, 8'h00, 0);
        chk("d1again_nd", r_nd0, 1);
        do_op(RD, 4'h1, 8'h00, 0);
        chk("r1_nef", r_nef0, 1);
        chk("r1_rd0", r_rd0, 0);
        do_op(RD, 4'h3, 8'h00, 5);
        chk("hold_cycles", r_held, 5);

        do_op(NOP, 4'h6, 8'h66, 0);
        repeat (5) @(negedge clk);
        chk("nop_ready", ready_o0, 1);
        chk("nop_occ", occ0, 2);

        @(posedge clk);
        #1;
        flush_i = 1'b1;
        valid_i = 1'b1;
        op      = WR;
        key_in  = 4'h2;
        data_in = 8'h11;
        @(negedge clk);
        chk("flush_rdy", ready_o0, 0);
        @(posedge clk);
        model_clear();
        #1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        @(negedge clk);
        chk("flush_occ", occ0, 0);
        repeat (3) @(negedge clk);
        chk("flush_noresp", valid_o0, 0);
        do_op(RD, 4'h2, 8'h00, 0);
        chk("flush_r2_nef", r_nef0, 1);

        do_op(WR, 4'h2, 8'h22, 0);
        chk("w2_ht", r_ht0, 0);
        do_op(WR, 4'h3, 8'h33, 0);
        chk("w3b_ht", r_ht0, 0);
        chk("w3b_occ", r_occ0, 2);

        @(posedge clk);
        #1;
        op      = WR;
        key_in  = 4'h1;
        data_in = 8'h99;
        valid_i = 1'b1;
        @(negedge clk);
        chk("pre_rst_rdy", ready_o0, 1);
        @(posedge clk);
        model_accept(0, WR, 4'h1, 8'h99);
        model_accept(1, WR, 4'h1, 8'h99);
        #1 valid_i = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_valid", valid_o0, 0);
        chk("mid_rst_occ", occ0, 0);
        chk("mid_rst_occ1", occ1, 0);
        model_clear();
        @(posedge clk);
        #2 reset = 1'b1;

        do_op(RD, 4'h1, 8'h00, 0);
        chk("post_rst_r1", r_nef0, 1);
        do_op(RD, 4'h3, 8'h00, 0);
        chk("post_rst_r3", r_nef0, 1);
        do_op(WR, 4'h1, 8'hEE, 0);
        chk("w1e_occ", r_occ0, 1);
        do_op(RD, 4'h1, 8'h00, 0);
        chk("r1e_data", r_rd0, 8'hEE);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, failed);
        $finish;
    end

endmodule
